// File: rtl/nmr_rxwin_pkg.sv
// Shared constants for the multi-channel RX/duplexer window generator.
// Channel states are one-hot so each state is a single flop.
package nmr_rxwin_pkg;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_DELAY  = 5'b00010;
    localparam logic [4:0] S_ARMED  = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_FIXED  = 5'b10000;

    localparam logic MODE_FOLLOW = 1'b0;
    localparam logic MODE_FIXED  = 1'b1;

endpackage

// File: rtl/nmr_rxwin_chan.sv
// One window channel: shadow registers, delay/length counter and state machine.
// The pulse and the gate rise together when the delay expires.
module nmr_rxwin_chan
    import nmr_rxwin_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          trg_i,
    input  logic          acq_en_i,
    input  logic          ch_en_i,
    input  logic          mode_i,
    input  logic [DW-1:0] delay_i,
    input  logic [DW-1:0] len_i,
    output logic          pulse_o,
    output logic          dly_o,
    output logic          busy_o
);

    localparam logic [DW-1:0] ONE = DW'(1);

    logic [4:0]    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] len_q, len_d;
    logic          mode_q, mode_d;
    logic          pulse_q, pulse_d;
    logic          dly_q, dly_d;
    logic          expire;
    logic [DW-1:0] delay_sat, len_sat;

    assign delay_sat = (delay_i == '0) ? ONE : delay_i;
    assign len_sat   = (len_i == '0) ? ONE : len_i;

    // The trigger edge itself counts as the first delay cycle, so DELAY is loaded with D-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        pulse_d = 1'b0;
        dly_d   = dly_q;
        expire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trg_i && ch_en_i) begin
                    len_d  = len_sat;
                    mode_d = mode_i;
                    if (delay_sat == ONE) begin
                        expire = 1'b1;
                    end else begin
                        cnt_d   = delay_sat - ONE;
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q <= ONE) expire = 1'b1;
                else              cnt_d  = cnt_q - ONE;
            end
            S_ARMED: begin
                if (acq_en_i) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!acq_en_i) begin
                    dly_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_FIXED: begin
                if (cnt_q <= ONE) begin
                    dly_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                dly_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (expire) begin
            pulse_d = 1'b1;
            dly_d   = 1'b1;
            if (mode_d == MODE_FOLLOW) begin
                state_d = acq_en_i ? S_ACTIVE : S_ARMED;
            end else begin
                state_d = S_FIXED;
                cnt_d   = len_d;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= ONE;
            mode_q  <= MODE_FOLLOW;
            pulse_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
            dly_q   <= dly_d;
        end
    end

    assign pulse_o = pulse_q;
    assign dly_o   = dly_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: rtl/nmr_rxwin_gen_mc.sv
// Multi-channel RX/duplexer window generator: synchronised ACQ_WND edge fans out
// to NUM_CH delayed pulse/gate channels with sticky missed-trigger flags.
module nmr_rxwin_gen_mc
    import nmr_rxwin_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 ADC_CLK,
    input  logic                 RESET,
    input  logic                 ACQ_WND,
    input  logic                 ACQ_EN,
    input  logic [NUM_CH*DW-1:0] RX_DELAY,
    input  logic [NUM_CH*DW-1:0] RX_LEN,
    input  logic [NUM_CH-1:0]    MODE,
    input  logic [NUM_CH-1:0]    CH_EN,
    input  logic                 CLR_MISSED,
    output logic [NUM_CH-1:0]    ACQ_WND_PULSED,
    output logic [NUM_CH-1:0]    ACQ_WND_DLY,
    output logic [NUM_CH-1:0]    MISSED_TRIG,
    output logic                 BUSY
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   trg_q;
    logic [NUM_CH-1:0]      missed_q, missed_d;
    logic [NUM_CH-1:0]      chan_busy;

    // A miss is judged against the pre-edge channel state, and a new miss beats the clear.
    assign missed_d = ({NUM_CH{trg_q}} & chan_busy) | (missed_q & ~{NUM_CH{CLR_MISSED}});

    always_ff @(posedge ADC_CLK or posedge RESET) begin
        if (RESET) begin
            sync_q   <= '0;
            edge_q   <= 1'b0;
            trg_q    <= 1'b0;
            missed_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ACQ_WND};
            edge_q   <= sync_q[SYNC_STAGES-1];
            trg_q    <= sync_q[SYNC_STAGES-1] & ~edge_q;
            missed_q <= missed_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            nmr_rxwin_chan #(.DW(DW)) u_chan (
                .clk_i    (ADC_CLK),
                .rst_i    (RESET),
                .trg_i    (trg_q),
                .acq_en_i (ACQ_EN),
                .ch_en_i  (CH_EN[gi]),
                .mode_i   (MODE[gi]),
                .delay_i  (RX_DELAY[gi*DW +: DW]),
                .len_i    (RX_LEN[gi*DW +: DW]),
                .pulse_o  (ACQ_WND_PULSED[gi]),
                .dly_o    (ACQ_WND_DLY[gi]),
                .busy_o   (chan_busy[gi])
            );
        end
    endgenerate

    assign MISSED_TRIG = missed_q;
    assign BUSY        = |chan_busy;

endmodule
